uart_rx_frame: RTL and testbench

- Receive-side counterpart of the team's RS485 frame transmitter (UARTTXBIG); sits on the far end of the link and consumes its serial line.
- Oversamples the line, recovers bytes, and writes them into a frame buffer (external 1-port RAM) by byte index.
- Delimits frames by byte count or idle gap, and reports frame completion, length and framing errors.

---
 rtl/uart_rx_frame_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_rx_frame.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_frame_pkg.sv
// Shared types and frame-format constants for the UART frame receiver.
package uart_rx_frame_pkg;

   // Receiver FSM states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_e;

   // Character format: 8 data bits, LSB first, one stop bit at logic high
   localparam int unsigned DATA_BITS  = 8;
   localparam logic        STOP_LEVEL = 1'b1;

endpackage : uart_rx_frame_pkg

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; resets to 1
// so an idle-high line does not look like an edge coming out of reset.
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Next values of the two synchronizer stages
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchronizer register pair, asynchronous active-low reset to 1
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule : uart_rx_sync

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver that writes bytes into a frame buffer by index
// and delimits frames by byte count or by an idle gap on the line.
module uart_rx_frame
   import uart_rx_frame_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = 8,
   parameter int unsigned BYTES      = 14,
   parameter int unsigned GAP_BITS   = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       wr_en,
   output logic [4:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       frame_done,
   output logic [4:0] frame_len,
   output logic       frame_err
);

   localparam int unsigned CNT_W   = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W   = $clog2(DATA_BITS);
   localparam int unsigned GAP_MAX = GAP_BITS * OVERSAMPLE;
   localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam logic [GAP_W-1:0] GAP_LIM  = GAP_W'(GAP_MAX);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
   localparam logic [4:0]       IDX_LAST = 5'(BYTES - 1);
   localparam logic [4:0]       IDX_FULL = 5'(BYTES);

   logic rxs;

   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [4:0]       idx_q, idx_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             rxs_prev_q, rxs_prev_d;
   logic             full_q, full_d;
   logic             wr_en_q, wr_en_d;
   logic [4:0]       wr_addr_q, wr_addr_d;
   logic [7:0]       wr_data_q, wr_data_d;
   logic             frame_done_q, frame_done_d;
   logic [4:0]       frame_len_q, frame_len_d;
   logic             frame_err_q, frame_err_d;
   logic             err_set;

   uart_rx_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rxs)
   );

   // Next-state, counters and output strobes of the receive FSM
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      idx_d        = idx_q;
      gap_d        = '0;
      rxs_prev_d   = rxs;
      full_d       = 1'b0;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      frame_done_d = 1'b0;
      frame_len_d  = frame_len_q;
      err_set      = 1'b0;

      // A full frame closes one cycle after its last write; the index was
      // already cleared when that byte was accepted.
      if (full_q) begin
         frame_done_d = 1'b1;
         frame_len_d  = IDX_FULL;
      end

      unique case (state_q)
         IDLE: begin
            if (rxs_prev_q && !rxs) begin
               state_d = START;
               cnt_d   = '0;
            end else if (rxs && (idx_q != '0)) begin
               gap_d = (gap_q != GAP_LIM) ? gap_q + GAP_ONE : gap_q;
               if (gap_q == GAP_LIM - GAP_ONE) begin
                  frame_done_d = 1'b1;
                  frame_len_d  = idx_q;
                  idx_d        = '0;
                  gap_d        = '0;
               end
            end
         end

         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               bit_d = '0;
               state_d = rxs ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         DATA: begin
            // Counter wrap marks mid-bit of each data bit
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == '1) begin
               shift_d[bit_q] = rxs;
               bit_d          = bit_q + BIT_ONE;
               if (bit_q == BIT_LAST) begin
                  state_d = STOP;
               end
            end
         end

         STOP: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == '1) begin
               if (rxs == STOP_LEVEL) begin
                  wr_en_d   = 1'b1;
                  wr_data_d = shift_q;
                  wr_addr_d = idx_q;
                  state_d   = IDLE;
                  if (idx_q == IDX_LAST) begin
                     idx_d  = '0;
                     full_d = 1'b1;
                  end else begin
                     idx_d = idx_q + 5'd1;
                  end
               end else begin
                  err_set = 1'b1;
                  state_d = BREAK;
               end
            end
         end

         BREAK: begin
            if (rxs) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // A fresh error wins over the clear that follows frame_done
      if (err_set) begin
         frame_err_d = 1'b1;
      end else if (frame_done_q) begin
         frame_err_d = 1'b0;
      end else begin
         frame_err_d = frame_err_q;
      end
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         idx_q        <= '0;
         gap_q        <= '0;
         rxs_prev_q   <= 1'b1;
         full_q       <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         frame_done_q <= 1'b0;
         frame_len_q  <= '0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         idx_q        <= idx_d;
         gap_q        <= gap_d;
         rxs_prev_q   <= rxs_prev_d;
         full_q       <= full_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         frame_done_q <= frame_done_d;
         frame_len_q  <= frame_len_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign frame_done = frame_done_q;
   assign frame_len  = frame_len_q;
   assign frame_err  = frame_err_q;

endmodule : uart_rx_frame

// File: tb/tb_uart_rx_frame.sv
// Directed self-checking bench for uart_rx_frame (OVERSAMPLE=8, BYTES=14, GAP_BITS=20).
module tb_uart_rx_frame;

   localparam int OS = 8;

   logic       clk;
   logic       reset;
   logic       rx;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic       frame_done;
   logic [4:0] frame_len;
   logic       frame_err;

   typedef struct {
      logic [4:0] addr;
      logic [7:0] data;
      int         cyc;
   } wr_t;

   typedef struct {
      logic [4:0] len;
      logic       err;
      int         cyc;
   } fd_t;

   wr_t  wr_q[$];
   fd_t  fd_q[$];
   logic fdn_q[$];
   int   cyc;
   int   n_chk;
   int   n_bad;
   int   n_coinc;
   logic fd_pend;

   uart_rx_frame #(
      .OVERSAMPLE (8),
      .BYTES      (14),
      .GAP_BITS   (20)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .frame_done (frame_done),
      .frame_len  (frame_len),
      .frame_err  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record strobes away from the active edge
   always @(negedge clk) begin
      if (fd_pend) fdn_q.push_back(frame_err);
      fd_pend = frame_done;
      if (wr_en) wr_q.push_back('{addr: wr_addr, data: wr_data, cyc: cyc});
      if (frame_done) fd_q.push_back('{len: frame_len, err: frame_err, cyc: cyc});
      if (wr_en && frame_done) n_coinc = n_coinc + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (obs !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (OS) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
   endtask

   task automatic clear_logs();
      wr_q.delete();
      fd_q.delete();
      fdn_q.delete();
   endtask

   initial begin
      cyc = 0; n_chk = 0; n_bad = 0; n_coinc = 0; fd_pend = 1'b0;
      rx = 1'b1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_wr_en", wr_en, 0);
      check_eq("rst_wr_addr", wr_addr, 0);
      check_eq("rst_wr_data", wr_data, 0);
      check_eq("rst_frame_done", frame_done, 0);
      check_eq("rst_frame_len", frame_len, 0);
      check_eq("rst_frame_err", frame_err, 0);
      reset = 1'b1;
      idle(20);

      // Single byte, closed by a 20 bit-time gap
      clear_logs();
      send_byte(8'hA5, 1'b1);
      idle(200);
      check_eq("a5_wr_count", wr_q.size(), 1);
      check_eq("a5_fd_count", fd_q.size(), 1);
      if (wr_q.size() == 1 && fd_q.size() == 1) begin
         check_eq("a5_addr", wr_q[0].addr, 0);
         check_eq("a5_data", wr_q[0].data, 8'hA5);
         check_eq("a5_len", fd_q[0].len, 1);
         check_eq("a5_gap_cycles", fd_q[0].cyc - wr_q[0].cyc, 160);
         check_eq("a5_err", fd_q[0].err, 0);
      end

      // 14 back-to-back bytes fill a frame
      clear_logs();
      for (int i = 0; i < 14; i++) send_byte(8'(i), 1'b1);
      idle(200);
      check_eq("full_wr_count", wr_q.size(), 14);
      for (int i = 0; i < wr_q.size() && i < 14; i++) begin
         check_eq($sformatf("full_addr%0d", i), wr_q[i].addr, i);
         check_eq($sformatf("full_data%0d", i), wr_q[i].data, i);
      end
      check_eq("full_fd_count", fd_q.size(), 1);
      if (fd_q.size() >= 1 && wr_q.size() == 14) begin
         check_eq("full_len", fd_q[0].len, 14);
         check_eq("full_done_lat", fd_q[0].cyc - wr_q[13].cyc, 1);
      end

      // Three-cycle low glitch is a false start
      clear_logs();
      rx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      idle(100);
      check_eq("glitch_wr_count", wr_q.size(), 0);
      check_eq("glitch_fd_count", fd_q.size(), 0);
      check_eq("glitch_err", frame_err, 0);

      // Bad stop bit, then a good byte
      clear_logs();
      send_byte(8'h3C, 1'b0);
      idle(30);
      check_eq("bad_stop_err", frame_err, 1);
      check_eq("bad_stop_no_wr", wr_q.size(), 0);
      send_byte(8'h55, 1'b1);
      idle(200);
      check_eq("err_wr_count", wr_q.size(), 1);
      if (wr_q.size() == 1) begin
         check_eq("err_addr", wr_q[0].addr, 0);
         check_eq("err_data", wr_q[0].data, 8'h55);
      end
      check_eq("err_fd_count", fd_q.size(), 1);
      if (fd_q.size() == 1 && fdn_q.size() == 1) begin
         check_eq("err_len", fd_q[0].len, 1);
         check_eq("err_at_done", fd_q[0].err, 1);
         check_eq("err_after_done", fdn_q[0], 0);
      end

      // 19 idle bit-times do not close the frame
      clear_logs();
      send_byte(8'h11, 1'b1);
      idle(19 * OS);
      send_byte(8'h22, 1'b1);
      idle(200);
      check_eq("gap19_wr_count", wr_q.size(), 2);
      if (wr_q.size() == 2) begin
         check_eq("gap19_addr1", wr_q[1].addr, 1);
         check_eq("gap19_data1", wr_q[1].data, 8'h22);
      end
      check_eq("gap19_fd_count", fd_q.size(), 1);
      if (fd_q.size() == 1) check_eq("gap19_len", fd_q[0].len, 2);

      // Reset in the middle of the second byte's data bits
      clear_logs();
      send_byte(8'h33, 1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      reset = 1'b0;
      #1;
      check_eq("mid_rst_wr_data", wr_data, 0);
      check_eq("mid_rst_frame_len", frame_len, 0);
      check_eq("mid_rst_wr_en", wr_en, 0);
      rx = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      idle(20);
      send_byte(8'h5A, 1'b1);
      idle(200);
      check_eq("mid_rst_wr_count", wr_q.size(), 2);
      if (wr_q.size() == 2) begin
         check_eq("mid_rst_addr", wr_q[1].addr, 0);
         check_eq("mid_rst_data", wr_q[1].data, 8'h5A);
      end
      check_eq("mid_rst_fd_count", fd_q.size(), 1);
      if (fd_q.size() == 1) check_eq("mid_rst_len", fd_q[0].len, 1);

      check_eq("no_coincidence", n_coinc, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule : tb_uart_rx_frame
